// File: rtl/sequential_signed_divider.sv
// ---------------------------------------------------------------------------
// sequential_signed_divider
//   Multi-cycle signed restoring divider. It produces one quotient bit per
//   clock by shifting left and doing a trial subtraction. The quotient is
//   truncated toward zero, and the remainder takes the sign of the dividend.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     start        request; sampled only while IDLE
//     dividend     signed dividend, captured on the accepting edge
//     divisor      signed divisor, captured on the accepting edge
//     quotient     signed quotient (held until the next result)
//     remainder    signed remainder (held until the next result)
//     busy         high in LOAD, ITER, FIX
//     ready        one-cycle pulse when quotient/remainder are valid
//     div_by_zero  valid with ready; divisor was zero
//     overflow     valid with ready; MIN / -1 (only with the macro)
//
//   Optional feature macro: DIV_OVERFLOW_DETECT_EN adds the overflow port.
//
//   Timing: start is accepted at edge 0. ready is high after edge WIDTH+2.
//   For a zero divisor, ready is high after edge 2.
// ---------------------------------------------------------------------------
module sequential_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero
`ifdef DIV_OVERFLOW_DETECT_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd_r;     // raw operands captured on the accepting edge
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] q_r;       // |dividend|, which becomes the quotient magnitude
    logic [WIDTH-1:0] m_r;       // |divisor|
    logic [WIDTH:0]   a_r;       // partial remainder
    logic [CW-1:0]    cnt;
    logic             neg_dvd;
    logic             neg_dvs;
    logic             dz_r;
`ifdef DIV_OVERFLOW_DETECT_EN
    logic             ovf_r;
`endif

    // Combined shift of {A,Q}: this is A shifted left with the Q MSB shifted in.
    // A is always below M, so its top bit is zero. That keeps the shifted value
    // inside WIDTH+1 bits, and the extra bit of trial only acts as a sign bit.
    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    always_comb begin
        sh      = {a_r, q_r[WIDTH-1]};
        trial   = sh - {2'b00, m_r};
        // The magnitude of MIN wraps to 2^(WIDTH-1). This is correct when the
        // value is read as unsigned.
        dvd_mag = dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
        dvs_mag = dvs_r[WIDTH-1] ? -dvs_r : dvs_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd_r       <= '0;
            dvs_r       <= '0;
            q_r         <= '0;
            m_r         <= '0;
            a_r         <= '0;
            cnt         <= '0;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            dz_r        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIV_OVERFLOW_DETECT_EN
            ovf_r       <= 1'b0;
            overflow    <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    q_r     <= dvd_mag;
                    m_r     <= dvs_mag;
                    a_r     <= '0;
                    cnt     <= '0;
                    neg_dvd <= dvd_r[WIDTH-1];
                    neg_dvs <= dvs_r[WIDTH-1];
                    dz_r    <= (dvs_r == '0);
`ifdef DIV_OVERFLOW_DETECT_EN
                    ovf_r   <= (dvd_r == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_r == '1);
`endif
                    state   <= (dvs_r == '0) ? FIX : ITER;
                end
                ITER: begin
                    if (!trial[WIDTH+1]) begin
                        a_r <= trial[WIDTH:0];
                        q_r <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        a_r <= sh[WIDTH:0];
                        q_r <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (dz_r) begin
                        quotient  <= '1;
                        remainder <= dvd_r;
                    end else begin
                        quotient  <= (neg_dvd ^ neg_dvs) ? -q_r : q_r;
                        remainder <= neg_dvd ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
                    end
                    div_by_zero <= dz_r;
`ifdef DIV_OVERFLOW_DETECT_EN
                    overflow    <= ovf_r;
`endif
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_signed_divider.sv
module tb_sequential_signed_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic [7:0] quotient, remainder;
    logic       busy, ready, div_by_zero;
`ifdef DIV_OVERFLOW_DETECT_EN
    logic       overflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sequential_signed_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .ready(ready),
        .div_by_zero(div_by_zero)
`ifdef DIV_OVERFLOW_DETECT_EN
        , .overflow(overflow)
`endif
    );

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer division truncates toward zero, and %
    // takes the sign of the dividend.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz,
                         output int lat);
        int ia, ib, iq, ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q = 8'hFF; r = a; dz = 1'b1; lat = 2;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q = iq[7:0]; r = ir[7:0]; dz = 1'b0; lat = 10;
        end
    endtask

    // Issues one request and waits for ready. lat is the number of edges
    // after the accepting edge; it is -1 if ready never arrives.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
        end
    endtask

    initial begin
        logic [7:0] eq, er, keep_q;
        logic       edz;
        int         elat, lat, seen;
        logic [7:0] ra, rb;

        tbl[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 10};
        tbl[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 10};
        tbl[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 10};
        tbl[3] = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 10};
        tbl[4] = '{8'd7,   8'h00,  8'hFF, 8'h07, 1'b1, 2};
        tbl[5] = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 10};
        tbl[6] = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 10};
        tbl[7] = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 10};
        tbl[8] = '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 10};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", 32'(quotient), 32'h0);
        check("rst_remainder", 32'(remainder), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_dz", 32'(div_by_zero), 32'h0);
`ifdef DIV_OVERFLOW_DETECT_EN
        check("rst_ovf", 32'(overflow), 32'h0);
`endif
        @(negedge clk); rst = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            run_div(tbl[i].dvd, tbl[i].dvs, lat);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_q", i), 32'(quotient), 32'(tbl[i].q));
            check($sformatf("tbl%0d_r", i), 32'(remainder), 32'(tbl[i].r));
            check($sformatf("tbl%0d_dz", i), 32'(div_by_zero), 32'(tbl[i].dz));
`ifdef DIV_OVERFLOW_DETECT_EN
            check($sformatf("tbl%0d_ovf", i), 32'(overflow),
                  32'(tbl[i].dvd == 8'h80 && tbl[i].dvs == 8'hFF));
`endif
        end

        // Results hold after the ready pulse
        keep_q = quotient;
        repeat (3) @(posedge clk);
        #1;
        check("hold_q", 32'(quotient), 32'(keep_q));
        check("ready_pulse_low", 32'(ready), 32'h0);

        // Randomized against the model
        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 8 == 0) rb = 8'h00;
            if (n % 11 == 0) begin ra = 8'h80; rb = 8'hFF; end
            if (n % 5 == 1) ra = 8'h80;
            model(ra, rb, eq, er, edz, elat);
            run_div(ra, rb, lat);
            check($sformatf("rnd%0d_lat(%0h/%0h)", n, ra, rb), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_q(%0h/%0h)", n, ra, rb), 32'(quotient), 32'(eq));
            check($sformatf("rnd%0d_r(%0h/%0h)", n, ra, rb), 32'(remainder), 32'(er));
            check($sformatf("rnd%0d_dz", n), 32'(div_by_zero), 32'(edz));
        end

        // A start pulse with new operands mid-ITER is ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        @(posedge clk); #1; start = 1'b0;
        lat = -1;
        for (int i = 6; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
        end
        check("midstart_lat", 32'(lat), 32'd10);
        check("midstart_q", 32'(quotient), 32'h0E);
        check("midstart_r", 32'(remainder), 32'h02);
        @(posedge clk); #1;
        check("midstart_idle", 32'(busy), 32'h0);

        // start held high through the ready cycle is accepted with no gap
        @(negedge clk);
        start = 1'b1; dividend = 8'h9C; divisor = 8'd7;
        @(posedge clk); #1;
        dividend = 8'd55; divisor = 8'hFA;            // -> -9 rem 1
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
        end
        check("b2b_first_lat", 32'(lat), 32'd10);
        check("b2b_first_q", 32'(quotient), 32'hF2);
        check("b2b_first_r", 32'(remainder), 32'hFE);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'h1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; break; end
        end
        check("b2b_second_lat", 32'(lat), 32'd10);
        check("b2b_second_q", 32'(quotient), 32'hF7);
        check("b2b_second_r", 32'(remainder), 32'h01);

        // An asynchronous reset mid-ITER aborts the division
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_quotient", 32'(quotient), 32'h0);
        check("arst_remainder", 32'(remainder), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ready", 32'(ready), 32'h0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("arst_no_ready", 32'(seen), 32'h0);
        run_div(8'd100, 8'd7, lat);
        check("arst_after_lat", 32'(lat), 32'd10);
        check("arst_after_q", 32'(quotient), 32'h0E);
        check("arst_after_r", 32'(remainder), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
